psk_phase_gen: RTL

- Transmit-side sequencer that drives the control and phase-offset inputs of the DDS phase accumulator: judge, T_cnt_flag, T_cnt, rom_addr_bpsk, rom_addr_qpsk.
- Generates pulse timing (on/off gating, period-start strobe) and per-chip phase codes: Barker-13 for BPSK, PRBS7 dibits for QPSK.
- Sits between the parameter/register interface and the accumulator. It is the producer end of the accumulator's modulation interface.

---
 rtl/psk_pkg.sv | 28 ++
 rtl/psk_phase_gen_if.sv | 13 +
 rtl/psk_code_src.sv | 65 ++++++
 rtl/psk_phase_gen.sv | 90 +++++++++
 4 files changed

// File: rtl/psk_pkg.sv
// Shared constants, state encoding and LFSR helpers for the PSK transmit sequencer.
package psk_pkg;

    localparam logic [5:0] WAVE_SIN  = 6'b000001;
    localparam logic [5:0] WAVE_COS  = 6'b000010;
    localparam logic [5:0] WAVE_LFM  = 6'b000100;
    localparam logic [5:0] WAVE_BPSK = 6'b001000;
    localparam logic [5:0] WAVE_QPSK = 6'b010000;
    localparam logic [5:0] WAVE_NLFM = 6'b100000;

    localparam logic [3:0] MODE_CW = 4'd1;

    localparam logic [12:0] BARKER13  = 13'b1111100110101;
    localparam logic [6:0]  LFSR_SEED = 7'h7F;
    // x^7 + x^6 + 1: feedback from the two oldest stages
    localparam logic [6:0]  LFSR_TAPS = 7'b1100000;

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    function automatic logic lfsr_fb(input logic [6:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

    function automatic logic [6:0] lfsr_step(input logic [6:0] s);
        return {s[5:0], lfsr_fb(s)};
    endfunction

endpackage

// File: rtl/psk_phase_gen_if.sv
// Modulation interface between the phase sequencer (master) and the DDS accumulator (slave).
interface psk_phase_gen_if #(
    parameter int ADDR_W = 23
);
    logic              judge;
    logic              T_cnt_flag;
    logic              T_cnt;
    logic [ADDR_W-1:0] rom_addr_bpsk;
    logic [ADDR_W-1:0] rom_addr_qpsk;

    modport master (output judge, T_cnt_flag, T_cnt, rom_addr_bpsk, rom_addr_qpsk);
    modport slave  (input  judge, T_cnt_flag, T_cnt, rom_addr_bpsk, rom_addr_qpsk);
endinterface

// File: rtl/psk_code_src.sv
// Chip timer plus Barker-13 / PRBS7 code state, mapped to registered phase offsets.
module psk_code_src
    import psk_pkg::*;
#(
    parameter int ADDR_W = 23,
    parameter int CHIP_W = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              restart,
    input  logic              enable,
    input  logic              bpsk_sel,
    input  logic              qpsk_sel,
    input  logic [CHIP_W-1:0] chip_len,
    output logic [ADDR_W-1:0] rom_addr_bpsk,
    output logic [ADDR_W-1:0] rom_addr_qpsk
);

    logic [CHIP_W-1:0] chip_cnt, cnt_n, chip_last;
    logic [3:0]        bark_idx, idx_n;
    logic [6:0]        lfsr, lfsr_n;
    logic              chip_bit;
    logic [1:0]        dibit;

    always_comb begin
        chip_last = (chip_len == '0) ? '0 : chip_len - CHIP_W'(1);
        cnt_n     = chip_cnt;
        idx_n     = bark_idx;
        lfsr_n    = lfsr;
        if (restart || !(bpsk_sel || qpsk_sel)) begin
            cnt_n  = '0;
            idx_n  = '0;
            lfsr_n = LFSR_SEED;
        end else if (enable) begin
            if (chip_cnt == chip_last) begin
                cnt_n  = '0;
                idx_n  = (bark_idx == 4'd12) ? 4'd0 : bark_idx + 4'd1;
                lfsr_n = lfsr_step(lfsr_step(lfsr));
            end else begin
                cnt_n = chip_cnt + CHIP_W'(1);
            end
        end
        // Phase registers load from the next code state, so a new chip shows one clock after terminal count
        chip_bit = BARKER13[4'd12 - idx_n];
        dibit    = {lfsr_fb(lfsr_n), lfsr_fb(lfsr_step(lfsr_n))};
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            chip_cnt      <= '0;
            bark_idx      <= '0;
            lfsr          <= LFSR_SEED;
            rom_addr_bpsk <= '0;
            rom_addr_qpsk <= '0;
        end else begin
            chip_cnt      <= cnt_n;
            bark_idx      <= idx_n;
            lfsr          <= lfsr_n;
            rom_addr_bpsk <= bpsk_sel ? {~chip_bit, {(ADDR_W-1){1'b0}}} : '0;
            // Gray: 00->0, 01->pi/2, 11->pi, 10->3pi/2
            rom_addr_qpsk <= qpsk_sel ? {dibit[1], ^dibit, {(ADDR_W-2){1'b0}}} : '0;
        end
    end

endmodule

// File: rtl/psk_phase_gen.sv
// Transmit sequencer: parameter change detect, PRI on/off gating and chip code generation.
module psk_phase_gen
    import psk_pkg::*;
#(
    parameter int ADDR_W = 23,
    parameter int CHIP_W = 16,
    parameter int PRD_W  = 24
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [5:0]        wave_sel,
    input  logic [3:0]        mode_sel,
    input  logic [CHIP_W-1:0] chip_len,
    input  logic [PRD_W-1:0]  pulse_period,
    input  logic [PRD_W-1:0]  pulse_width,
    psk_phase_gen_if.master   mod_if
);

    localparam int PAR_W = 6 + 4 + CHIP_W + 2 * PRD_W;

    logic [PAR_W-1:0] params_live, shadow;
    state_t           state, state_n;
    logic [PRD_W-1:0] prd_cnt, prd_n;
    logic             changed, pulsed, on_last, wrap, flag_n, tcnt_n;

    // Live inputs equal the shadow except on the change edge, where the new set must take effect
    always_comb begin
        params_live = {wave_sel, mode_sel, chip_len, pulse_period, pulse_width};
        changed     = (params_live != shadow);
        pulsed      = (mode_sel != MODE_CW) && (pulse_width < pulse_period);
        on_last     = (pulse_width == '0) ? (prd_cnt == '0)
                                          : (prd_cnt == pulse_width - PRD_W'(1));
        wrap        = (state != IDLE) && (prd_cnt == pulse_period - PRD_W'(1));
        state_n     = state;
        prd_n       = prd_cnt;
        flag_n      = 1'b0;
        tcnt_n      = 1'b0;
        if (changed) begin
            state_n = (pulse_period == '0) ? IDLE : ON;
            prd_n   = '0;
        end else begin
            flag_n = (state != IDLE) && (prd_cnt == '0);
            tcnt_n = (state == OFF);
            if (state != IDLE) begin
                if (wrap) begin
                    prd_n   = '0;
                    state_n = ON;
                end else begin
                    prd_n = prd_cnt + PRD_W'(1);
                    if (state == ON && pulsed && on_last)
                        state_n = OFF;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shadow            <= '0;
            state             <= IDLE;
            prd_cnt           <= '0;
            mod_if.judge      <= 1'b0;
            mod_if.T_cnt_flag <= 1'b0;
            mod_if.T_cnt      <= 1'b0;
        end else begin
            shadow            <= params_live;
            state             <= state_n;
            prd_cnt           <= prd_n;
            mod_if.judge      <= changed;
            mod_if.T_cnt_flag <= flag_n;
            mod_if.T_cnt      <= tcnt_n;
        end
    end

    psk_code_src #(
        .ADDR_W (ADDR_W),
        .CHIP_W (CHIP_W)
    ) u_code_src (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .restart       (changed || wrap),
        .enable        (state == ON),
        .bpsk_sel      (wave_sel == WAVE_BPSK),
        .qpsk_sel      (wave_sel == WAVE_QPSK),
        .chip_len      (chip_len),
        .rom_addr_bpsk (mod_if.rom_addr_bpsk),
        .rom_addr_qpsk (mod_if.rom_addr_qpsk)
    );

endmodule
